// File: rtl/rz_arbiter.sv
// Interrupt request arbiter: edge-captures sources into RZ, masks with RM, and
// holds the lowest-numbered request on irq/ivec until P-M acknowledges it.
// Optional RZ_NMI_EN: source 0 bypasses the mask.
module rz_arbiter #(
  parameter int unsigned N  = 32,
  parameter int unsigned VW = 5
) (
  input  logic          clk,
  input  logic          clm,
  input  logic [N-1:0]  src,
  input  logic          w_rz,
  input  logic          w_rm,
  input  logic [N-1:0]  wdata,
  input  logic          ack,
  output logic          irq,
  output logic [VW-1:0] ivec,
  output logic [N-1:0]  rz,
  output logic [N-1:0]  rm
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    CLR  = 2'b10
  } state_t;

  state_t          r_state;
  logic            r_irq;
  logic [VW-1:0]   r_ivec;
  logic [N-1:0]    r_rz;
  logic [N-1:0]    r_rm;
  logic [N-1:0]    r_src_d;

  logic [N-1:0]    w_set;
  logic [N-1:0]    w_clr;
  logic [N-1:0]    w_eff;
  logic [VW-1:0]   w_pick;
  logic            w_found;

  assign w_set = src & ~r_src_d;
  assign w_clr = (r_state == CLR) ? (N'(1) << r_ivec) : '0;

  always_comb begin
    w_eff = r_rz & r_rm;
`ifdef RZ_NMI_EN
    w_eff[0] = r_rz[0];
`endif
  end

  // Fixed priority: bit 0 wins, so keep only the first hit in ascending order.
  always_comb begin
    w_pick  = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!w_found && w_eff[i]) begin
        w_pick  = VW'(i);
        w_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge clm) begin
    if (clm) begin
      r_src_d <= '0;
      r_rz    <= '0;
      r_rm    <= '0;
    end else begin
      r_src_d <= src;
      if (w_rz) r_rz <= wdata | w_set;
      else      r_rz <= (r_rz & ~w_clr) | w_set;
      if (w_rm) r_rm <= wdata;
    end
  end

  always_ff @(posedge clk or posedge clm) begin
    if (clm) begin
      r_state <= IDLE;
      r_irq   <= 1'b0;
      r_ivec  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_ivec  <= w_pick;
            r_irq   <= 1'b1;
            r_state <= REQ;
          end
        end
        REQ: begin
          if (ack) begin
            r_irq   <= 1'b0;
            r_state <= CLR;
          end else if (w_rz && !wdata[r_ivec]) begin
            r_irq   <= 1'b0;
            r_state <= IDLE;
          end
        end
        CLR: r_state <= IDLE;
        default: begin
          r_irq   <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign irq  = r_irq;
  assign ivec = r_ivec;
  assign rz   = r_rz;
  assign rm   = r_rm;

endmodule

// File: doc/rz_arbiter.md
Name: rz_arbiter

Overview:
- Interrupt request arbiter ahead of the P-M unit.
- Captures interrupt source edges into the pending register (RZ) and qualifies them with the interrupt mask (RM).
- Selects the highest-priority pending request and drives the single `irq` level consumed by P-M.
- Holds a stable vector number until P-M acknowledges the interrupt (interrupt-receive cycle), then clears the serviced RZ bit.

Parameters:
- N, 32, number of interrupt sources / RZ and RM width.
- VW, 5, vector width; must satisfy 2**VW >= N.

Ports:
- clk  input  1  system clock.
- clm  input  1  asynchronous active-high reset (master clear).
- src  input  N  interrupt source levels, synchronous to clk; a rising edge requests an interrupt.
- w_rz  input  1  one-cycle strobe: load RZ from `wdata`.
- w_rm  input  1  one-cycle strobe: load RM from `wdata`.
- wdata  input  N  write data for RZ/RM.
- ack  input  1  one-cycle strobe from P-M: the interrupt has been received.
- irq  output  1  interrupt request to P-M.
- ivec  output  VW  number of the granted source; valid while `irq`=1.
- rz  output  N  pending register.
- rm  output  N  mask register.

Behaviour:
- Reset (`clm`=1, asynchronous): rz=0, rm=0, src history=0, state=IDLE, irq=0, ivec=0.
- Edge detect:
  - `src_d` registers `src` every cycle.
  - `set = src & ~src_d`.
  - The history register is cleared by `clm`, so a source held high through reset produces an edge on the first cycle after reset.
- RZ next value, in priority order:
  1. `w_rz`: rz <= wdata | set.
  2. Otherwise: rz <= (rz & ~clr) | set.
  - `clr` is the one-hot of `ivec`, applied only on the CLR transition.
  - Set always wins over clear on the same bit.
- RM: rm <= wdata on `w_rm`; otherwise hold.
- Effective request: `eff = rz & rm`.
- Priority: bit 0 highest, bit N-1 lowest (fixed order).
- States (2-bit encoding):
  - IDLE:
    - irq=0.
    - If eff != 0, latch ivec = index of the lowest set bit of eff and go to REQ.
  - REQ:
    - irq=1 and ivec frozen.
    - Changes to RZ/RM/src do not re-arbitrate, including a masked-out or higher-priority arrival.
    - On `ack`, go to CLR.
    - `w_rz` with wdata[ivec]=0 (software withdrawal) goes to IDLE without ack. irq drops on the next cycle. If `ack` arrives in the same cycle, ack wins and the state goes to CLR.
  - CLR:
    - irq=0 for exactly one cycle.
    - rz[ivec] is cleared in this cycle, unless set or `w_rz` overrides.
    - Unconditionally return to IDLE.
- Latency:
  - src edge -> rz bit set: 1 cycle.
  - rz/rm write -> irq: 2 cycles (register, then IDLE->REQ).
  - ack -> next irq: 3 cycles minimum (CLR, IDLE, REQ).
- `ack` in IDLE or CLR is ignored.
- irq and ivec are registered outputs; ivec holds its last value in IDLE and CLR.
- Reset mid-REQ: irq drops asynchronously and the pending request is lost.

Optional Feature:
- Macro: RZ_NMI_EN.
- When defined:
  - Source 0 is non-maskable: eff[0] = rz[0] regardless of rm[0].
  - rm[0] still reads back its written value.
  - When N=1 the arbiter behaves as a pure edge latch.
- When undefined: every source obeys RM.

Test Plan:
- Reset, then rm=all 1s, pulse src[5] -> rz=0x20 after 1 cycle; irq=1, ivec=5 two cycles after the edge. Pulse ack -> irq=0, rz=0 one cycle later; irq stays 0.
- rm=all 1s, src[3] and src[9] edges in the same cycle -> ivec=3. After ack and CLR, irq reasserts with ivec=9 exactly 3 cycles after ack.
- rm=0xFFFFFFFE, rz written 0x1 -> irq stays 0 (RZ_NMI_EN undefined). With RZ_NMI_EN defined -> irq=1, ivec=0.
- In REQ with ivec=7, src[2] edge arrives -> ivec stays 7 until ack. Then rz=0x4 and the next grant is ivec=2.
- In CLR with ivec=4, src[4] edge in the same cycle -> rz[4] remains 1 and irq reasserts with ivec=4.
- In REQ with ivec=6, `w_rz` with wdata=0 -> irq=0 next cycle, state IDLE, no ack needed. Separately, assert `clm` during REQ -> irq=0 immediately, rz=0, rm=0.
